// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
//   LEGv8 instruction-decode stage with a one-entry ID/EX output register.
//   Decodes register indices, reads the register file (with optional
//   writeback-to-read forwarding), extends the immediate field and checks
//   for a load-use hazard against the load currently sitting in EX.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake for inst
//   inst, Reg2Loc       instruction word; Reg2Loc picks rs2 = inst[4:0]
//                       (1) or inst[20:16] (0)
//   wb_en/wb_reg/wb_data  register-file writeback port
//   ex_mem_read, ex_rd  load in EX, used for the load-use hazard check
//   flush               discard the ID/EX contents and the current input
//   out_valid/out_ready downstream handshake
//   out_r_data1/2       register operands captured at acceptance
//   out_ex_data         extended immediate
//   out_rd, out_inst    destination index and raw instruction
// ---------------------------------------------------------------------------
module id_stage_pipe #(
    parameter int WORD   = 64,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic            Reg2Loc,
    input  logic            wb_en,
    input  logic [4:0]      wb_reg,
    input  logic [WORD-1:0] wb_data,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WORD-1:0] out_r_data1,
    output logic [WORD-1:0] out_r_data2,
    output logic [WORD-1:0] out_ex_data,
    output logic [4:0]      out_rd,
    output logic [31:0]     out_inst
);

    localparam int         IW  = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [4:0] XZR = 5'(NREG - 1);

    logic [WORD-1:0] regs [NREG];

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [WORD-1:0] r_data1;
    logic [WORD-1:0] r_data2;
    logic [WORD-1:0] ex_data;
    logic            hazard;
    logic            advance;
    logic            accept;

    // XZR and any index beyond the physical file read as zero and are never written.
    function automatic logic is_real(input logic [4:0] r);
        return int'(r) < (NREG - 1);
    endfunction

    // Field decode: rs2 moves to the rd slot for stores and CB-type branches.
    always_comb begin
        rs1 = inst[9:5];
        rd  = inst[4:0];
        rs2 = Reg2Loc ? inst[4:0] : inst[20:16];
    end

    // Register file storage; reset clears every register, including the
    // unused XZR slot, so no state survives a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && is_real(wb_reg)) begin
            regs[IW'(wb_reg)] <= wb_data;
        end
    end

    // Read ports. With forwarding enabled a same-cycle writeback to the
    // register being read wins over the stored value.
    always_comb begin
        r_data1 = '0;
        r_data2 = '0;
        if (is_real(rs1)) begin
            if ((BYPASS != 0) && wb_en && (wb_reg == rs1)) begin
                r_data1 = wb_data;
            end else begin
                r_data1 = regs[IW'(rs1)];
            end
        end
        if (is_real(rs2)) begin
            if ((BYPASS != 0) && wb_en && (wb_reg == rs2)) begin
                r_data2 = wb_data;
            end else begin
                r_data2 = regs[IW'(rs2)];
            end
        end
    end

    // Immediate extension by instruction format; anything unrecognised
    // passes the raw instruction through zero-extended.
    always_comb begin
        ex_data = {{(WORD-32){1'b0}}, inst};
        if (inst[31:26] == 6'b000101) begin
            ex_data = {{(WORD-26){inst[25]}}, inst[25:0]};
        end else if (inst[31:25] == 7'b1011010) begin
            ex_data = {{(WORD-19){inst[23]}}, inst[23:5]};
        end else if ((inst[31:21] == 11'b11111000010) ||
                     (inst[31:21] == 11'b11111000000)) begin
            ex_data = {{(WORD-9){inst[20]}}, inst[20:12]};
        end else if ((inst[31:22] == 10'b1001000100) ||
                     (inst[31:22] == 10'b1101000100)) begin
            ex_data = {{(WORD-12){1'b0}}, inst[21:10]};
        end
    end

    // Handshake. A load in EX writing XZR never creates a hazard. in_ready is
    // held low during reset so nothing is taken before the pipe is clean.
    always_comb begin
        hazard   = in_valid && ex_mem_read && (ex_rd != XZR) &&
                   ((ex_rd == rs1) || (ex_rd == rs2));
        advance  = !out_valid || out_ready;
        in_ready = advance && !hazard && !flush && !rst;
        accept   = in_valid && in_ready;
    end

    // ID/EX output register. Bubbles and flushes only clear out_valid; the
    // data fields keep their last contents. A stall holds everything, so
    // later writebacks never refresh an operand already captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_r_data1 <= '0;
            out_r_data2 <= '0;
            out_ex_data <= '0;
            out_rd      <= '0;
            out_inst    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            if (accept) begin
                out_valid   <= 1'b1;
                out_r_data1 <= r_data1;
                out_r_data2 <= r_data2;
                out_ex_data <= ex_data;
                out_rd      <= rd;
                out_inst    <= inst;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_stage_pipe
//   Directed bench for id_stage_pipe. Two instances share every input: the
//   default one with forwarding and one built without it. Accepted
//   instructions push hand-computed expectations into a queue; a monitor
//   pops and compares whenever an output handshake happens.
// ---------------------------------------------------------------------------
module tb_id_stage_pipe;

    localparam int WORD = 64;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] r1;
        logic [63:0] r2;
        logic [63:0] r2_nb;
        logic [63:0] ex;
        logic [4:0]  rd;
    } exp_t;

    logic            tb_clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic            reg2loc;
    logic            wb_en;
    logic [4:0]      wb_reg;
    logic [WORD-1:0] wb_data;
    logic            ex_mem_read;
    logic [4:0]      ex_rd;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [WORD-1:0] out_r_data1;
    logic [WORD-1:0] out_r_data2;
    logic [WORD-1:0] out_ex_data;
    logic [4:0]      out_rd;
    logic [31:0]     out_inst;

    logic            nb_in_ready;
    logic            nb_out_valid;
    logic [WORD-1:0] nb_r_data1;
    logic [WORD-1:0] nb_r_data2;
    logic [WORD-1:0] nb_ex_data;
    logic [4:0]      nb_rd;
    logic [31:0]     nb_inst;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 tb_clk = ~tb_clk;

    id_stage_pipe #(.WORD(WORD), .NREG(32), .BYPASS(1)) u_dut (
        .clk(tb_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .Reg2Loc(reg2loc), .wb_en(wb_en), .wb_reg(wb_reg),
        .wb_data(wb_data), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_r_data1(out_r_data1), .out_r_data2(out_r_data2),
        .out_ex_data(out_ex_data), .out_rd(out_rd), .out_inst(out_inst)
    );

    id_stage_pipe #(.WORD(WORD), .NREG(32), .BYPASS(0)) u_dut_nb (
        .clk(tb_clk), .rst(rst), .in_valid(in_valid), .in_ready(nb_in_ready),
        .inst(inst), .Reg2Loc(reg2loc), .wb_en(wb_en), .wb_reg(wb_reg),
        .wb_data(wb_data), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .flush(flush), .out_valid(nb_out_valid), .out_ready(out_ready),
        .out_r_data1(nb_r_data1), .out_r_data2(nb_r_data2),
        .out_ex_data(nb_ex_data), .out_rd(nb_rd), .out_inst(nb_inst)
    );

    task automatic check_output(input string name, input logic [63:0] act,
                                input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    // Called at posedge+1. Holds the instruction until the bench sees
    // in_ready high before an edge, then records the expected output.
    task automatic apply_stimulus(input logic [31:0] i, input logic r2l,
                                  input logic [4:0] rd, input logic [63:0] ex,
                                  input logic [63:0] r1, input logic [63:0] r2,
                                  input logic [63:0] r2_nb);
        exp_t e;
        bit   done = 1'b0;
        e.inst  = i;
        e.rd    = rd;
        e.ex    = ex;
        e.r1    = r1;
        e.r2    = r2;
        e.r2_nb = r2_nb;
        in_valid = 1'b1;
        inst     = i;
        reg2loc  = r2l;
        for (int k = 0; k < 16 && !done; k++) begin
            @(negedge tb_clk);
            if (in_ready === 1'b1) begin
                sb_q.push_back(e);
                done = 1'b1;
            end
            step();
        end
        in_valid = 1'b0;
        if (!done) check_output("accept_timeout", 64'd0, 64'd1);
    endtask

    // Scoreboard monitor: one pop per completed output handshake.
    always @(negedge tb_clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_output("sb_unexpected_output", {32'd0, out_inst}, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_output("out_inst",     {32'd0, out_inst}, {32'd0, mon_e.inst});
                check_output("out_rd",       {59'd0, out_rd},   {59'd0, mon_e.rd});
                check_output("out_ex_data",  out_ex_data,       mon_e.ex);
                check_output("out_r_data1",  out_r_data1,       mon_e.r1);
                check_output("out_r_data2",  out_r_data2,       mon_e.r2);
                check_output("nb_out_valid", {63'd0, nb_out_valid}, 64'd1);
                check_output("nb_r_data1",   nb_r_data1,        mon_e.r1);
                check_output("nb_r_data2",   nb_r_data2,        mon_e.r2_nb);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; inst = '0; reg2loc = 1'b0;
        wb_en = 1'b0; wb_reg = '0; wb_data = '0; ex_mem_read = 1'b0;
        ex_rd = '0; flush = 1'b0; out_ready = 1'b1;

        // Reset with a pending instruction and writeback that must be ignored.
        step();
        in_valid = 1'b1; inst = 32'hF84402C9;
        wb_en = 1'b1; wb_reg = 5'd5; wb_data = 64'h33;
        @(negedge tb_clk);
        check_output("rst_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        rst = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
        @(negedge tb_clk);
        check_output("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_output("rst_r_data1", out_r_data1, 64'd0);
        check_output("rst_r_data2", out_r_data2, 64'd0);
        check_output("rst_ex_data", out_ex_data, 64'd0);
        check_output("rst_rd", {59'd0, out_rd}, 64'd0);
        check_output("rst_inst", {32'd0, out_inst}, 64'd0);
        step();

        // LDUR X9,[X22,#64]
        apply_stimulus(32'hF84402C9, 1'b0, 5'd9, 64'd64, 64'd0, 64'd0, 64'd0);

        // ADD X10,X19,X9 with X9<=1 written in the same cycle
        wb_en = 1'b1; wb_reg = 5'd9; wb_data = 64'd1;
        apply_stimulus(32'h8B09026A, 1'b0, 5'd10, 64'h8B09026A, 64'd0, 64'd1, 64'd0);
        wb_reg = 5'd19; wb_data = 64'h1234; step();
        wb_reg = 5'd10; wb_data = 64'h55;   step();
        wb_reg = 5'd11; wb_data = 64'hAA;   step();
        wb_en = 1'b0;
        apply_stimulus(32'h8B09026A, 1'b0, 5'd10, 64'h8B09026A, 64'h1234, 64'd1, 64'd1);

        // Extension formats; the B runs with a load to XZR in EX (no hazard)
        apply_stimulus(32'hB4FFFF6B, 1'b1, 5'd11, 64'hFFFFFFFFFFFFFFFB, 64'd0, 64'hAA, 64'hAA);
        ex_mem_read = 1'b1; ex_rd = 5'd31;
        apply_stimulus(32'h17FFFFC9, 1'b0, 5'd9, 64'hFFFFFFFFFFFFFFC9, 64'd0, 64'd0, 64'd0);
        ex_mem_read = 1'b0;
        apply_stimulus(32'h913FFC41, 1'b0, 5'd1, 64'hFFF, 64'd0, 64'd0, 64'd0);

        // Load-use hazard on rs2 (X10), then on rs1 (X20)
        in_valid = 1'b1; inst = 32'h8B0A028B; reg2loc = 1'b0;
        ex_mem_read = 1'b1; ex_rd = 5'd10;
        @(negedge tb_clk);
        check_output("hazard_rs2_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        @(negedge tb_clk);
        check_output("hazard_bubble_valid", {63'd0, out_valid}, 64'd0);
        step();
        ex_rd = 5'd20;
        @(negedge tb_clk);
        check_output("hazard_rs1_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        ex_mem_read = 1'b0;
        apply_stimulus(32'h8B0A028B, 1'b0, 5'd11, 64'h8B0A028B, 64'd0, 64'h55, 64'h55);

        // Stall three cycles with a new instruction waiting and a writeback
        // to a captured operand register.
        apply_stimulus(32'h8B09026A, 1'b0, 5'd10, 64'h8B09026A, 64'h1234, 64'd1, 64'd1);
        out_ready = 1'b0; in_valid = 1'b1; inst = 32'h8B0A028B;
        wb_en = 1'b1; wb_reg = 5'd19; wb_data = 64'h9999;
        for (int k = 0; k < 3; k++) begin
            @(negedge tb_clk);
            check_output("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check_output("stall_out_valid", {63'd0, out_valid}, 64'd1);
            check_output("stall_out_inst", {32'd0, out_inst}, 64'h8B09026A);
            check_output("stall_r_data1", out_r_data1, 64'h1234);
            step();
            wb_en = 1'b0;
        end
        out_ready = 1'b1;
        apply_stimulus(32'h8B0A028B, 1'b0, 5'd11, 64'h8B0A028B, 64'd0, 64'h55, 64'h55);
        apply_stimulus(32'h8B09026A, 1'b0, 5'd10, 64'h8B09026A, 64'h9999, 64'd1, 64'd1);

        // XZR: writes ignored, same-cycle and later reads give zero
        wb_en = 1'b1; wb_reg = 5'd31; wb_data = 64'd5;
        apply_stimulus(32'h8B1F03E0, 1'b0, 5'd0, 64'h8B1F03E0, 64'd0, 64'd0, 64'd0);
        wb_en = 1'b0;
        apply_stimulus(32'h8B1F03E0, 1'b0, 5'd0, 64'h8B1F03E0, 64'd0, 64'd0, 64'd0);

        // Flush during a stall; writeback in the flush cycle still lands
        apply_stimulus(32'h8B0500A1, 1'b0, 5'd1, 64'h8B0500A1, 64'd0, 64'd0, 64'd0);
        out_ready = 1'b0;
        @(negedge tb_clk);
        check_output("flush_pre_valid", {63'd0, out_valid}, 64'd1);
        step();
        flush = 1'b1; in_valid = 1'b1; inst = 32'hF84402C9;
        wb_en = 1'b1; wb_reg = 5'd5; wb_data = 64'h77;
        @(negedge tb_clk);
        check_output("flush_in_ready", {63'd0, in_ready}, 64'd0);
        sb_q.delete();
        step();
        flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        @(negedge tb_clk);
        check_output("flush_out_valid", {63'd0, out_valid}, 64'd0);
        step();
        apply_stimulus(32'h8B0500A1, 1'b0, 5'd1, 64'h8B0500A1, 64'h77, 64'h77, 64'h77);

        // Reset during a stall drops the held instruction and clears X5
        apply_stimulus(32'h8B0500A1, 1'b0, 5'd1, 64'h8B0500A1, 64'h77, 64'h77, 64'h77);
        out_ready = 1'b0;
        @(negedge tb_clk);
        check_output("rst_stall_pre_valid", {63'd0, out_valid}, 64'd1);
        step();
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; inst = 32'hF84402C9;
        wb_en = 1'b1; wb_reg = 5'd5; wb_data = 64'h33;
        @(negedge tb_clk);
        check_output("rst_stall_in_ready", {63'd0, in_ready}, 64'd0);
        sb_q.delete();
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
        @(negedge tb_clk);
        check_output("rst_stall_out_valid", {63'd0, out_valid}, 64'd0);
        check_output("rst_stall_out_inst", {32'd0, out_inst}, 64'd0);
        check_output("rst_stall_r_data1", out_r_data1, 64'd0);
        out_ready = 1'b1;
        step();
        apply_stimulus(32'h8B0500A1, 1'b0, 5'd1, 64'h8B0500A1, 64'd0, 64'd0, 64'd0);

        repeat (3) step();
        @(negedge tb_clk);
        check_output("sb_drain_pending", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
